// File: rtl/codificador_teclado_16_4.sv
// codificador_teclado_16_4: debounced 16-line key encoder with valid/ready output
// Ports: clk, rst_n (async active-low); entrada[15:0] raw keys; listo consumer ready;
// codigo[3:0] held key index; valido untransferred event; ocupado press held;
// perdido one-cycle pulse on a press dropped because the output was full.
module codificador_teclado_16_4 #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] entrada,
  input  logic        listo,
  output logic [3:0]  codigo,
  output logic        valido,
  output logic        ocupado,
  output logic        perdido
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, CHECK, HELD, RELEASE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0] cand, cand_nx, p_code;
  logic [15:0] s1, s;
  logic p_any, ev;
  assign p_any = |s;
  always_comb begin
    p_code = '0;
    for (int i = 0; i < 16; i++) p_code = s[i] ? i[3:0] : p_code;
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    cand_nx = cand;
    ev = 1'b0;
    case (state)
      IDLE:
        if (p_any) begin
          state_nx = CHECK;
          cand_nx = p_code;
          cnt_nx = '0;
        end
      CHECK:
        if (!p_any || p_code != cand) state_nx = IDLE;
        else if (cnt == CNT_MAX) begin
          state_nx = HELD;
          ev = 1'b1;
        end else cnt_nx = cnt + CW'(1);
      HELD:
        if (!p_any) begin
          state_nx = RELEASE;
          cnt_nx = '0;
        end
      RELEASE:
        if (p_any) begin
          state_nx = HELD;
          cnt_nx = '0;
        end else if (cnt == CNT_MAX) state_nx = IDLE;
        else cnt_nx = cnt + CW'(1);
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s <= '0;
      state <= IDLE;
      cnt <= '0;
      cand <= '0;
      codigo <= '0;
      valido <= 1'b0;
      ocupado <= 1'b0;
      perdido <= 1'b0;
    end else begin
      s1 <= entrada;
      s <= s1;
      state <= state_nx;
      cnt <= cnt_nx;
      cand <= cand_nx;
      ocupado <= (state_nx == HELD) || (state_nx == RELEASE);
      perdido <= ev && valido && !listo;
      if (ev && (!valido || listo)) begin
        codigo <= cand;
        valido <= 1'b1;
      end else if (!ev && valido && listo) valido <= 1'b0;
    end
  end
endmodule

// File: doc/codificador_teclado_16_4.md
# codificador_teclado_16_4

Debounced 16-line key encoder: samples 16 raw, asynchronous, active-high key lines. It synchronizes and debounces them, then priority-encodes the pressed key into a 4-bit code. It delivers one code per press to the Morse transmitter core over a valid/ready handshake. It is the inverse of the system's 4-to-16 one-hot decoder and sits between the front-panel keypad and the symbol-selection logic.

## Interface
- DEBOUNCE_CYCLES, 16, number of consecutive stable cycles required to accept a press or a release; legal range ≥1; counter width = $clog2(DEBOUNCE_CYCLES+1).
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- entrada  input  16  raw key lines, asynchronous, bit i high = key i pressed.
- listo  input  1  consumer ready; transfer occurs on an edge with valido=1 and listo=1.
- codigo  output  4  encoded key index of the held event; stable while valido=1.
- valido  output  1  codigo holds an untransferred event.
- ocupado  output  1  a debounced press is currently held (states HELD, RELEASE).
- perdido  output  1  one-cycle pulse: an accepted press was dropped because the output register was full.

## Operation
- Synchronizer: two flops per bit; s = second stage. All following logic sees s only.
- Priority encoder on s: p_any = |s; p_code = index of highest set bit (bit 15 wins).
- FSM states: IDLE, CHECK, HELD, RELEASE; one counter cnt and one candidate register cand[3:0].
  - IDLE: p_any=1 → CHECK, cand←p_code, cnt←0.
  - CHECK: p_any=0 or p_code≠cand → IDLE. If cnt=DEBOUNCE_CYCLES-1 → HELD and raise press event with cand. Otherwise cnt←cnt+1.
  - HELD: p_any=1 → stay. A change of key while held generates no event. p_any=0 → RELEASE, cnt←0.
  - RELEASE: p_any=1 → HELD, cnt←0. If cnt=DEBOUNCE_CYCLES-1 → IDLE. Otherwise cnt←cnt+1.
- Output register:
  - Press event with valido=0, or with valido=1 and listo=1 on the same edge → codigo←cand, valido←1.
  - Press event with valido=1 and listo=0 → event dropped; codigo and valido unchanged; perdido=1 for one cycle.
  - No event with valido=1 and listo=1 → valido←0; codigo retains its last value.
- ocupado = (state==HELD) or (state==RELEASE), registered.
- One press yields exactly one event, regardless of hold duration or bouncing.

## Timing
- Reset (rst_n=0, immediate, asynchronous): sync flops 0, state IDLE, cnt 0, cand 0, codigo 0, valido 0, ocupado 0, perdido 0. Deassertion takes effect at the next edge.
- Reset mid-operation: a pending code is lost; the FSM restarts from IDLE. A key still held after reset is re-detected as a new press.
- Press latency: counting from the first edge that samples the new entrada value, valido rises after edge 3+DEBOUNCE_CYCLES. ocupado rises on the same edge.
- Release latency: ocupado falls after edge 3+DEBOUNCE_CYCLES, counted from the first edge sampling entrada=0.
- Handshake: codigo and valido hold while listo=0. Transfer consumes one cycle; back-to-back transfers are possible with no idle cycle.
- perdido is high for exactly the one cycle following the dropping edge. It is never high while valido transitions 0→1.
- Bounce shorter than DEBOUNCE_CYCLES during CHECK restarts detection. Bounce during RELEASE returns the FSM to HELD without a new event.

## Test plan
- Reset: rst_n=0 with entrada=16'hFFFF for 5 cycles → all outputs 0. Release with DEBOUNCE_CYCLES=4, listo=0 → valido=1, codigo=4'hF after edge 7, ocupado=1.
- Single press: DEBOUNCE_CYCLES=4, listo=1, entrada=16'h0020 for 20 cycles then 0 → one valido cycle with codigo=5 after edge 7; ocupado falls 7 edges after release; no second event.
- Bounce: bit 3 toggles every 2 cycles for 10 cycles, then stays high (DEBOUNCE_CYCLES=4) → exactly one event, codigo=3, first valido ≥7 edges after bouncing stops.
- Priority and key change: entrada=16'h8101 → codigo=4'hF. Then entrada changes to 16'h0001 without release → no new event, ocupado stays 1.
- Backpressure: listo=0, press key 2, full release, press key 9 → valido=1, codigo=2 held; perdido pulses once at key 9 acceptance. Then listo=1 → transfer, valido=0 next cycle.
- Simultaneous consume and event: valido=1 (codigo=2), listo=1 on the same edge key 7 is accepted → codigo=7, valido stays 1, perdido=0. Assert rst_n=0 in the next cycle → valido=0 immediately.
